// File: rtl/result_mem_if_if.sv
// Bundle for the write-back stage: the two MAC result streams coming in
// and the BRAM write port going out.
//   res0_valid/res0 : column-0 accumulator stream
//   res1_valid/res1 : column-1 accumulator stream
//   bram_addr/en/we/din : single write port towards the output BRAM
// The write-back block masters the BRAM port, so it takes the master view;
// the stream producers and the memory side take the slave view.
interface result_mem_if_if #(
    parameter int ACC_W  = 32,
    parameter int BRAM_W = 64,
    parameter int AW     = 8
);
    logic              res0_valid;
    logic [ACC_W-1:0]  res0;
    logic              res1_valid;
    logic [ACC_W-1:0]  res1;
    logic [AW-1:0]     bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [BRAM_W-1:0] bram_din;

    modport master (
        input  res0_valid, res0, res1_valid, res1,
        output bram_addr, bram_en, bram_we, bram_din
    );

    modport slave (
        output res0_valid, res0, res1_valid, res1,
        input  bram_addr, bram_en, bram_we, bram_din
    );
endinterface

// File: rtl/result_mem_if.sv
// Write-back stage behind the MAC row. Requantizes two accumulator streams
// (round-half-up, arithmetic shift, saturate to DATA_W), packs WPR words per
// BRAM row and writes each completed row to the output BRAM in column-major
// order: column 0 rows first, column 1 rows RPC rows later.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : arms a job (sampled only when idle)
//   base_addr      : first BRAM row of the job, latched on start
//   bus (master)   : result streams in, BRAM write port out
//   busy, done     : job in progress / one-cycle completion pulse
//   sat_cnt        : clamped words in the current job, sticks at 255
//   ovf_err        : sticky, a result arrived after its column was full
module result_mem_if #(
    parameter int N         = 4,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int SHIFT     = 8,
    parameter int BRAM_W    = 64,
    parameter int MEM_DEPTH = 256,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    result_mem_if_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            sat_cnt,
    output logic                  ovf_err
);
    localparam int WPR = BRAM_W / DATA_W;
    localparam int RPC = N / WPR;
    localparam int CW  = $clog2(N + 1);
    localparam int WB  = (WPR > 1) ? $clog2(WPR) : 1;

    // Requantization constants, all at ACC_W+1 bits so the rounding add is exact.
    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_W:0] MAX_T = (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MIN_T = (ACC_W+1)'(-(64'sd1 <<< (DATA_W - 1)));
    localparam logic [DATA_W-1:0]     MAX_W = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]     MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

    // Returns {clamped, word}.
    function automatic logic [DATA_W:0] requant(input logic [ACC_W-1:0] r);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] t;
        logic [DATA_W:0]       res;
        ext = $signed({r[ACC_W-1], r});
        t   = (ext + RND) >>> SHIFT;
        if (t > MAX_T) begin
            res = {1'b1, MAX_W};
        end else if (t < MIN_T) begin
            res = {1'b1, MIN_W};
        end else begin
            res = {1'b0, t[DATA_W-1:0]};
        end
        return res;
    endfunction

    state_t            state_r, state_s;
    logic [AW-1:0]     base_r, base_s;
    logic [CW-1:0]     cnt0_r, cnt0_s, cnt1_r, cnt1_s;
    logic [BRAM_W-1:0] pack0_r, pack0_s, pack1_r, pack1_s;
    logic              pend1_r, pend1_s;
    logic [BRAM_W-1:0] pend1_row_r, pend1_row_s;
    logic [AW-1:0]     pend1_addr_r, pend1_addr_s;
    logic              we_r, we_s;
    logic [AW-1:0]     addr_r, addr_s;
    logic [BRAM_W-1:0] din_r, din_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [7:0]        sat_r, sat_s;
    logic              ovf_r, ovf_s;

    logic              acc0_s, acc1_s, full0_s, full1_s;
    logic [DATA_W:0]   q0_s, q1_s;
    logic [WB-1:0]     slot0_s, slot1_s;
    logic [AW-1:0]     row0_addr_s, row1_addr_s;
    logic [8:0]        sat_sum_s;

    // Next-state, packing, arbitration and status logic.
    always_comb begin
        state_s      = state_r;
        base_s       = base_r;
        cnt0_s       = cnt0_r;
        cnt1_s       = cnt1_r;
        pack0_s      = pack0_r;
        pack1_s      = pack1_r;
        pend1_s      = pend1_r;
        pend1_row_s  = pend1_row_r;
        pend1_addr_s = pend1_addr_r;
        we_s         = 1'b0;
        addr_s       = addr_r;
        din_s        = din_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        sat_s        = sat_r;
        ovf_s        = ovf_r;

        q0_s        = requant(bus.res0);
        q1_s        = requant(bus.res1);
        slot0_s     = cnt0_r[WB-1:0];
        slot1_s     = cnt1_r[WB-1:0];
        acc0_s      = (state_r == COLLECT) && bus.res0_valid && (cnt0_r < CW'(N));
        acc1_s      = (state_r == COLLECT) && bus.res1_valid && (cnt1_r < CW'(N));
        full0_s     = acc0_s && (slot0_s == WB'(WPR - 1));
        full1_s     = acc1_s && (slot1_s == WB'(WPR - 1));
        row0_addr_s = base_r + AW'(cnt0_r >> WB);
        row1_addr_s = base_r + AW'(RPC) + AW'(cnt1_r >> WB);
        sat_sum_s   = {1'b0, sat_r} + {8'd0, acc0_s & q0_s[DATA_W]}
                                    + {8'd0, acc1_s & q1_s[DATA_W]};

        case (state_r)
            IDLE: begin
                if (start) begin
                    base_s  = base_addr;
                    cnt0_s  = '0;
                    cnt1_s  = '0;
                    pack0_s = '0;
                    pack1_s = '0;
                    pend1_s = 1'b0;
                    sat_s   = 8'd0;
                    ovf_s   = 1'b0;
                    busy_s  = 1'b1;
                    state_s = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (acc0_s) begin
                    pack0_s[int'(slot0_s)*DATA_W +: DATA_W] = q0_s[DATA_W-1:0];
                    cnt0_s = cnt0_r + CW'(1);
                end else if ((cnt0_r == CW'(N)) && bus.res0_valid) begin
                    ovf_s = 1'b1;
                end else begin
                    cnt0_s = cnt0_r;
                end
                if (acc1_s) begin
                    pack1_s[int'(slot1_s)*DATA_W +: DATA_W] = q1_s[DATA_W-1:0];
                    cnt1_s = cnt1_r + CW'(1);
                end else if ((cnt1_r == CW'(N)) && bus.res1_valid) begin
                    ovf_s = 1'b1;
                end else begin
                    cnt1_s = cnt1_r;
                end
                sat_s = (sat_sum_s > 9'd255) ? 8'd255 : sat_sum_s[7:0];

                // Column 0 always writes the cycle after its row fills; a column-1
                // row that loses arbitration waits one cycle in the pending slot.
                if (full0_s) begin
                    we_s   = 1'b1;
                    addr_s = row0_addr_s;
                    din_s  = pack0_s;
                    if (full1_s) begin
                        pend1_s      = 1'b1;
                        pend1_row_s  = pack1_s;
                        pend1_addr_s = row1_addr_s;
                    end else begin
                        pend1_s = pend1_r;
                    end
                end else if (pend1_r) begin
                    we_s   = 1'b1;
                    addr_s = pend1_addr_r;
                    din_s  = pend1_row_r;
                    if (full1_s) begin
                        pend1_row_s  = pack1_s;
                        pend1_addr_s = row1_addr_s;
                    end else begin
                        pend1_s = 1'b0;
                    end
                end else if (full1_s) begin
                    we_s   = 1'b1;
                    addr_s = row1_addr_s;
                    din_s  = pack1_s;
                end else begin
                    we_s = 1'b0;
                end

                // Leave while the last row write is on the port, so done lands
                // exactly one cycle after it.
                if ((cnt0_r == CW'(N)) && (cnt1_r == CW'(N)) && !pend1_r && !we_s) begin
                    state_s = FINISH;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = COLLECT;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, write port and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r       <= '0;
            cnt0_r       <= '0;
            cnt1_r       <= '0;
            pack0_r      <= '0;
            pack1_r      <= '0;
            pend1_r      <= 1'b0;
            pend1_row_r  <= '0;
            pend1_addr_r <= '0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            din_r        <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            sat_r        <= 8'd0;
            ovf_r        <= 1'b0;
        end else begin
            base_r       <= base_s;
            cnt0_r       <= cnt0_s;
            cnt1_r       <= cnt1_s;
            pack0_r      <= pack0_s;
            pack1_r      <= pack1_s;
            pend1_r      <= pend1_s;
            pend1_row_r  <= pend1_row_s;
            pend1_addr_r <= pend1_addr_s;
            we_r         <= we_s;
            addr_r       <= addr_s;
            din_r        <= din_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            sat_r        <= sat_s;
            ovf_r        <= ovf_s;
        end
    end

    assign bus.bram_we   = we_r;
    assign bus.bram_en   = we_r;
    assign bus.bram_addr = addr_r;
    assign bus.bram_din  = din_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign sat_cnt       = sat_r;
    assign ovf_err       = ovf_r;
endmodule

// File: tb/tb_result_mem_if.sv
module tb_result_mem_if;
    localparam int N = 4, DATA_W = 16, ACC_W = 32, SHIFT = 8, BRAM_W = 64, MEM_DEPTH = 256;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic busy, done, ovf_err;
    logic [7:0] sat_cnt;

    result_mem_if_if #(.ACC_W(ACC_W), .BRAM_W(BRAM_W), .AW(AW)) bus ();

    result_mem_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT),
                    .BRAM_W(BRAM_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .bus(bus), .busy(busy), .done(done), .sat_cnt(sat_cnt), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write / done monitor, sampled mid-cycle.
    logic [AW-1:0] wr_addr[$];
    logic [63:0]   wr_data[$];
    int            wr_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic          busy_at_done = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bram_we === 1'b1) begin
                wr_addr.push_back(bus.bram_addr);
                wr_data.push_back(bus.bram_din);
                wr_cyc.push_back(cyc);
                chk("bram_en_at_write", {63'd0, bus.bram_en}, 64'd1);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    // Reference requantizer: round half up, floor shift, clamp.
    function automatic logic [15:0] rq(input logic [31:0] r, output bit sat);
        longint v, t;
        v = longint'($signed(r));
        t = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        if (t > 32767) begin
            sat = 1'b1; return 16'h7FFF;
        end else if (t < -32768) begin
            sat = 1'b1; return 16'h8000;
        end
        sat = 1'b0;
        return 16'(t);
    endfunction

    function automatic logic [63:0] exp_row(input logic [31:0] q[$], input int first, inout int nsat);
        logic [63:0] row;
        bit s;
        row = '0;
        for (int i = 0; i < 4; i++) begin
            row[i*16 +: 16] = rq(q[first + i], s);
            nsat += int'(s);
        end
        return row;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0: r = $urandom;
            1: r = $urandom & 32'h00FFFFFF;
            2: r = $urandom & 32'h000FFFFF;
            default: r = 32'h007FFF00 + ($urandom & 32'h000001FF);
        endcase
        if ($urandom_range(0, 1) == 1) r = 32'd0 - r;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_col(input int col, input logic v, input logic [31:0] d);
        if (col == 0) begin
            bus.res0_valid = v; bus.res0 = d;
        end else begin
            bus.res1_valid = v; bus.res1 = d;
        end
    endtask

    task automatic drive_stream(input int col, input logic [31:0] vals[$], input int offset,
                                input int max_gap, output int last);
        last = -1;
        repeat (offset) step();
        foreach (vals[k]) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) step();
            set_col(col, 1'b1, vals[k]);
            last = cyc;
            step();
            set_col(col, 1'b0, 32'd0);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1; base_addr = b;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            step();
            n++;
        end
        chk("done_seen_once", 64'(done_cnt), 64'd1);
    endtask

    // Checks a finished job against the model, independent of write order.
    task automatic check_job(input string name, input logic [AW-1:0] b,
                             input logic [31:0] q0[$], input logic [31:0] q1[$], input logic exp_ovf);
        int nsat, h0, h1, exp_sat;
        logic [63:0] r0, r1;
        logic [AW-1:0] a0, a1;
        nsat = 0;
        r0 = exp_row(q0, 0, nsat);
        r1 = exp_row(q1, 0, nsat);
        a0 = b;
        a1 = b + AW'(1);
        exp_sat = (nsat > 255) ? 255 : nsat;
        h0 = 0; h1 = 0;
        chk({name, "_nwrites"}, 64'(wr_addr.size()), 64'd2);
        foreach (wr_addr[i]) begin
            if (wr_addr[i] == a0) begin
                h0++; chk({name, "_row0"}, wr_data[i], r0);
            end else if (wr_addr[i] == a1) begin
                h1++; chk({name, "_row1"}, wr_data[i], r1);
            end else begin
                chk({name, "_addr"}, 64'(wr_addr[i]), 64'(a0));
            end
        end
        chk({name, "_hits"}, 64'({h0[7:0], h1[7:0]}), 64'h0101);
        if (wr_cyc.size() > 0) chk({name, "_done_cyc"}, 64'(done_cyc), 64'(wr_cyc[wr_cyc.size()-1] + 1));
        chk({name, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        chk({name, "_sat"}, 64'(sat_cnt), 64'(exp_sat));
        chk({name, "_ovf"}, 64'(ovf_err), 64'(exp_ovf));
    endtask

    typedef struct {
        logic [AW-1:0]      base;
        logic [3:0][31:0]   r0;
        logic [3:0][31:0]   r1;
        logic [AW-1:0]      a0, a1;
        logic [63:0]        row0, row1;
        int                 sat;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [31:0] q0[$], q1[$];
        int l0, l1, l2;

        // Directed vectors with hand-computed rows.
        vecs[0].base = 8'h10; vecs[0].a0 = 8'h10; vecs[0].a1 = 8'h11;
        for (int k = 0; k < 4; k++) begin
            vecs[0].r0[k] = 32'(k) << 8;
            vecs[0].r1[k] = 32'(k + 4) << 8;
        end
        vecs[0].row0 = 64'h0003_0002_0001_0000; vecs[0].row1 = 64'h0007_0006_0005_0004; vecs[0].sat = 0;

        vecs[1].base = 8'h40; vecs[1].a0 = 8'h40; vecs[1].a1 = 8'h41;
        vecs[1].r0[0] = 32'h0000_1280; vecs[1].r0[1] = 32'h0000_127F;
        vecs[1].r0[2] = 32'hFFFF_FE80; vecs[1].r0[3] = 32'h0000_0000;
        vecs[1].r1[0] = 32'h7FFF_FFFF; vecs[1].r1[1] = 32'h8000_0000;
        vecs[1].r1[2] = 32'h0080_0000; vecs[1].r1[3] = 32'h007F_FF7F;
        vecs[1].row0 = 64'h0000_FFFF_0012_0013; vecs[1].row1 = 64'h7FFF_7FFF_8000_7FFF; vecs[1].sat = 3;

        vecs[2].base = 8'hFF; vecs[2].a0 = 8'hFF; vecs[2].a1 = 8'h00;
        vecs[2].r0[0] = 32'hFFFF_FFFF; vecs[2].r0[1] = 32'hFFFF_FF80;
        vecs[2].r0[2] = 32'hFFFF_FF7F; vecs[2].r0[3] = 32'h007F_FF80;
        vecs[2].r1[0] = 32'hFF80_0000; vecs[2].r1[1] = 32'hFF7F_FF80;
        vecs[2].r1[2] = 32'hFF7F_FF7F; vecs[2].r1[3] = 32'h0000_0100;
        vecs[2].row0 = 64'h7FFF_FFFF_0000_0000; vecs[2].row1 = 64'h0001_8000_8000_8000; vecs[2].sat = 2;

        bus.res0_valid = 1'b0; bus.res0 = '0; bus.res1_valid = 1'b0; bus.res1 = '0;
        #2;
        chk("rst_bram_we", 64'(bus.bram_we), 64'd0);
        chk("rst_bram_en", 64'(bus.bram_en), 64'd0);
        chk("rst_bram_addr", 64'(bus.bram_addr), 64'd0);
        chk("rst_bram_din", bus.bram_din, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sat", 64'(sat_cnt), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Table-driven simultaneous streams with exact timing.
        for (int v = 0; v < 3; v++) begin
            q0 = {}; q1 = {};
            for (int k = 0; k < 4; k++) begin
                q0.push_back(vecs[v].r0[k]);
                q1.push_back(vecs[v].r1[k]);
            end
            clear_log();
            do_start(vecs[v].base);
            chk("vec_busy", 64'(busy), 64'd1);
            fork
                drive_stream(0, q0, 0, 0, l0);
                drive_stream(1, q1, 0, 0, l1);
            join
            wait_done();
            chk("vec_nwrites", 64'(wr_addr.size()), 64'd2);
            if (wr_addr.size() == 2) begin
                chk("vec_addr0", 64'(wr_addr[0]), 64'(vecs[v].a0));
                chk("vec_row0", wr_data[0], vecs[v].row0);
                chk("vec_cyc0", 64'(wr_cyc[0]), 64'(l0 + 1));
                chk("vec_addr1", 64'(wr_addr[1]), 64'(vecs[v].a1));
                chk("vec_row1", wr_data[1], vecs[v].row1);
                chk("vec_cyc1", 64'(wr_cyc[1]), 64'(l1 + 2));
            end
            chk("vec_done_cyc", 64'(done_cyc), 64'(l0 + 3));
            chk("vec_busy_at_done", 64'(busy_at_done), 64'd0);
            step(); step();
            chk("vec_sat_hold", 64'(sat_cnt), 64'(vecs[v].sat));
            chk("vec_ovf", 64'(ovf_err), 64'd0);
        end

        // Overrun on column 0 plus a start pulse while busy.
        q0 = {}; q1 = {};
        for (int k = 0; k < 5; k++) q0.push_back(rnd_val());
        for (int k = 0; k < 4; k++) q1.push_back(rnd_val());
        clear_log();
        do_start(8'h30);
        fork
            drive_stream(0, q0, 0, 0, l0);
            drive_stream(1, q1, 8, 0, l1);
            begin
                repeat (3) step();
                start = 1'b1; base_addr = 8'h80;
                step();
                start = 1'b0;
            end
        join
        wait_done();
        check_job("ovr", 8'h30, q0, q1, 1'b1);
        step();

        // Staggered and stalled streams, then randomized jobs.
        for (int j = 0; j < 25; j++) begin
            logic [AW-1:0] b;
            int off;
            b = AW'($urandom);
            off = (j == 0) ? 5 : int'($urandom_range(0, 6));
            q0 = {}; q1 = {};
            for (int k = 0; k < 4; k++) begin
                q0.push_back(rnd_val());
                q1.push_back(rnd_val());
            end
            clear_log();
            do_start(b);
            fork
                drive_stream(0, q0, 0, 3, l0);
                drive_stream(1, q1, off, 3, l1);
            join
            wait_done();
            check_job((j == 0) ? "stagger" : "rand", b, q0, q1, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset in the middle of a job.
        q0 = {}; q1 = {};
        for (int k = 0; k < 2; k++) begin
            q0.push_back(32'h0000_1100 + 32'(k));
            q1.push_back(32'h0000_2200 + 32'(k));
        end
        clear_log();
        do_start(8'h50);
        fork
            drive_stream(0, q0, 0, 0, l0);
            drive_stream(1, q1, 0, 0, l1);
        join
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(bus.bram_we), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_sat", 64'(sat_cnt), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("midrst_no_writes", 64'(wr_addr.size() + done_cnt), 64'd0);
        q0 = {}; q1 = {};
        for (int k = 0; k < 4; k++) begin
            q0.push_back(vecs[0].r0[k]);
            q1.push_back(vecs[0].r1[k]);
        end
        clear_log();
        do_start(8'h20);
        fork
            drive_stream(0, q0, 0, 1, l0);
            drive_stream(1, q1, 0, 1, l2);
        join
        wait_done();
        check_job("postrst", 8'h20, q0, q1, 1'b0);
        chk("postrst_row0_const", (wr_addr.size() > 0 && wr_addr[0] == 8'h20) ? wr_data[0] : wr_data[wr_data.size()-1],
            vecs[0].row0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/result_mem_if.md
# result_mem_if

Write-back stage downstream of the MAC row. It accepts the two result streams produced by the MACs fed from `weight_mem_if`, one per weight column. Each accumulator result is requantized to `DATA_W` bits with rounding and saturation. Four words are packed per `BRAM_W` row, and each completed row is written back to the output BRAM in the same column-major layout the weight loader reads.

## Interface
Parameters:
- `N`, 4, results per column; must be a multiple of `BRAM_W/DATA_W` and at least 4.
- `DATA_W`, 16, stored word width, signed.
- `ACC_W`, 32, MAC accumulator width, signed.
- `SHIFT`, 8, requantization right shift; must be at least 1.
- `BRAM_W`, 64, BRAM row width.
- `MEM_DEPTH`, 256, BRAM depth in rows.

Ports (AW = $clog2(MEM_DEPTH)):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  arms a job; sampled only in IDLE.
- `base_addr`  in  AW  first BRAM row of the job; latched on `start`.
- `res0_valid`  in  1  `res0` is valid this cycle.
- `res0`  in  ACC_W  column-0 result, signed.
- `res1_valid`  in  1  `res1` is valid this cycle.
- `res1`  in  ACC_W  column-1 result, signed.
- `bram_addr`  out  AW  write address.
- `bram_en`  out  1  equals `bram_we`.
- `bram_we`  out  1  one-cycle write strobe.
- `bram_din`  out  BRAM_W  packed row.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse when the job completes.
- `sat_cnt`  out  8  saturated words in the current job; holds at 255.
- `ovf_err`  out  1  sticky flag: a result arrived beyond N for its column.

## Operation
- Reset: all outputs are 0, the FSM is in IDLE, and both packers and pending flags are cleared. Reset takes effect asynchronously mid-job; `bram_we` drops immediately.
- Derived constants: WPR = BRAM_W/DATA_W = 4 and RPC = N/WPR.
- Address map:
  - Column 0, word k goes to row `base_addr + k/WPR`, slot k%WPR.
  - Column 1, word k goes to row `base_addr + RPC + k/WPR`.
  - Slot s occupies `bram_din[s*DATA_W +: DATA_W]`.
  - Address arithmetic wraps modulo MEM_DEPTH.
- Requantization, per result r:
  - Compute t = (r + 2^(SHIFT-1)) >>> SHIFT, evaluated at ACC_W+1 bits so the add cannot overflow.
  - If t > 2^(DATA_W-1)-1, store 0x7FFF. If t < -2^(DATA_W-1), store 0x8000. Otherwise store t[DATA_W-1:0].
  - Each clamp increments `sat_cnt`, saturating at 255.
- FSM states:
  - IDLE: `busy`=0. On `start`, latch `base_addr`, clear the counters, the packers, `sat_cnt` and `ovf_err`, set `busy`=1, and go to COLLECT. A `start` while not in IDLE is ignored. Valid inputs are ignored in IDLE.
  - COLLECT: each column has an independent word counter cnt0/cnt1 (0..N) and a packing register. A valid result with cnt<N is requantized into slot cnt%WPR and cnt increments. A valid result with cnt==N is dropped and sets `ovf_err`. Both columns may accept in the same cycle. When a column's slot WPR-1 is filled, that row becomes a pending write for the column.
  - Write arbitration: at most one write per cycle, and column 0 wins. A losing column-1 row stays pending and is written the next cycle. Refilling a row takes at least WPR cycles, so one pending slot per column suffices.
  - When cnt0==N, cnt1==N and no write is pending or in flight, go to FINISH.
  - FINISH: pulse `done`=1, set `busy`=0, and go to IDLE.

## Timing
- Row write: the last word of a row is accepted in cycle t. `bram_we`=1 with `bram_addr`/`bram_din` valid in cycle t+1, for exactly one cycle.
- Simultaneous row completion in cycle t: the column-0 write occurs at t+1 and the column-1 write at t+2.
- Completion: the final `bram_we` occurs in cycle w. `done`=1 and `busy`=0 occur in cycle w+1. `start` is accepted from cycle w+2.
- Minimum job length: simultaneous streams of N cycles plus 3 cycles.
- `sat_cnt` and `ovf_err` are valid at `done` and hold until the next accepted `start`.
- Result streams may stall (valid low) at any cycle; packing resumes where it stopped.

## Test plan
- N=4, `base_addr`=0x10, simultaneous res0=k<<8 and res1=(k+4)<<8 for k=0..3 → row 0x10 receives 0x0003_0002_0001_0000 at t+1. Row 0x11 receives 0x0007_0006_0005_0004 at t+2. `done` follows one cycle later and `sat_cnt`=0.
- Rounding: res0 = 0x1280, 0x127F, 0xFFFFFE80 (-384), 0 → packed words are 0x0013, 0x0012, 0xFFFF, 0x0000.
- Saturation: res1 = 0x7FFFFFFF, 0x80000000, 0x00800000, 0x007FFF7F → words are 0x7FFF, 0x8000, 0x7FFF, 0x7FFF. `sat_cnt` is 3, because the last value rounds to exactly 0x7FFF without clamping.
- Staggered and stalled streams: column 1 starts 5 cycles after column 0, with random valid gaps → exactly 2 writes, at the correct addresses, no write collision, one `done`.
- Overrun and ignore: a fifth res0 after cnt0=4 sets `ovf_err` and leaves memory unchanged. A `start` pulsed while busy leaves `base_addr` unchanged.
- Reset mid-job: assert `rst_n`=0 after 2 of 4 words → `bram_we`, `busy` and `done` are 0 immediately. After release, a new job at 0x20 writes clean rows with no stale words.
